// File: rtl/sys_req_master.sv
// Host byte-stream to sys_req bridge: 52/57 command frames become one register transaction, status (+ read data) returned.
// Read request 1 cycle after address byte, status 2 cycles after completion; rsp stream holds under rsp_ready=0, cmd_ready low while busy.
module sys_req_master #(
    parameter int MGNT_REG_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 16
) (
    input  logic       clk_if,
    input  logic       rst_if,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       rsp_ready,
    output logic       sys_req_valid,
    output logic       sys_req_wr,
    output logic [7:0] sys_req_addr,
    output logic [7:0] sys_req_data,
    output logic       sys_req_data_valid,
    input  logic       sys_req_ack,
    input  logic [7:0] sys_resp_data,
    input  logic       sys_resp_data_valid
);
    localparam int REG_BYTES = MGNT_REG_WIDTH / 8;
    localparam int CW        = $clog2(REG_BYTES + 1);

    localparam logic [CW-1:0]        CNT_LAST = CW'(REG_BYTES - 1);
    localparam logic [CW-1:0]        CNT_FULL = CW'(REG_BYTES);
    localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OP_RD    = 8'h52;
    localparam logic [7:0] OP_WR    = 8'h57;
    localparam logic [7:0] ST_OK    = 8'h00;
    localparam logic [7:0] ST_TO    = 8'h01;
    localparam logic [7:0] ST_BADOP = 8'h02;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, REQ, XFER, GAP, RSP} state_t;

    state_t                    state;
    logic                      wr;
    logic [7:0]                addr;
    logic [7:0]                status;
    logic [CW-1:0]             cnt;
    logic                      ack_flg;
    logic [TIMEOUT_W-1:0]      tcnt;
    logic [MGNT_REG_WIDTH-1:0] wbuf;
    logic [MGNT_REG_WIDTH-1:0] rbuf;

    logic cmd_fire;
    logic ack_now;
    logic data_done;
    logic xfer_done;
    logic rsp_last;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign ack_now   = ack_flg || sys_req_ack;
    // A read byte arriving in the completing cycle still counts toward the data phase.
    assign data_done = wr ? (cnt == CNT_FULL)
                          : ((cnt == CNT_FULL) || (sys_resp_data_valid && (cnt == CNT_LAST)));
    assign xfer_done = ack_now && data_done;
    assign rsp_last  = (status != ST_OK) || wr || (cnt == CNT_FULL);

    always_ff @(posedge clk_if) begin
        if (!rst_if) begin
            state              <= IDLE;
            wr                 <= 1'b0;
            addr               <= 8'h00;
            status             <= 8'h00;
            cnt                <= '0;
            ack_flg            <= 1'b0;
            tcnt               <= '0;
            wbuf               <= '0;
            rbuf               <= '0;
            cmd_ready          <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_data           <= 8'h00;
            sys_req_valid      <= 1'b0;
            sys_req_wr         <= 1'b0;
            sys_req_addr       <= 8'h00;
            sys_req_data       <= 8'h00;
            sys_req_data_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        if (cmd_data == OP_RD || cmd_data == OP_WR) begin
                            wr    <= (cmd_data == OP_WR);
                            state <= ADDR;
                        end else begin
                            wr        <= 1'b0;
                            status    <= ST_BADOP;
                            cnt       <= '0;
                            cmd_ready <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_data  <= ST_BADOP;
                            state     <= RSP;
                        end
                    end
                end
                ADDR: begin
                    if (cmd_fire) begin
                        addr <= cmd_data;
                        cnt  <= '0;
                        if (wr) begin
                            state <= WDATA;
                        end else begin
                            cmd_ready     <= 1'b0;
                            sys_req_valid <= 1'b1;
                            sys_req_wr    <= 1'b0;
                            sys_req_addr  <= cmd_data;
                            state         <= REQ;
                        end
                    end
                end
                WDATA: begin
                    if (cmd_fire) begin
                        // Shift in so the first (MSB) byte ends up at the top.
                        wbuf <= MGNT_REG_WIDTH'({wbuf, cmd_data});
                        if (cnt == CNT_LAST) begin
                            cmd_ready     <= 1'b0;
                            sys_req_valid <= 1'b1;
                            sys_req_wr    <= 1'b1;
                            sys_req_addr  <= addr;
                            state         <= REQ;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                REQ: begin
                    ack_flg <= 1'b0;
                    tcnt    <= '0;
                    rbuf    <= '0;
                    if (wr) begin
                        sys_req_data_valid <= 1'b1;
                        sys_req_data       <= wbuf[MGNT_REG_WIDTH-1 -: 8];
                        wbuf               <= wbuf << 8;
                        cnt                <= CW'(1);
                    end else begin
                        cnt <= '0;
                    end
                    state <= XFER;
                end
                XFER: begin
                    if (wr) begin
                        if (cnt != CNT_FULL) begin
                            sys_req_data_valid <= 1'b1;
                            sys_req_data       <= wbuf[MGNT_REG_WIDTH-1 -: 8];
                            wbuf               <= wbuf << 8;
                            cnt                <= cnt + 1'b1;
                        end else begin
                            sys_req_data_valid <= 1'b0;
                            sys_req_data       <= 8'h00;
                        end
                    end else if (sys_resp_data_valid && cnt != CNT_FULL) begin
                        rbuf <= MGNT_REG_WIDTH'({rbuf, sys_resp_data});
                        cnt  <= cnt + 1'b1;
                    end
                    ack_flg <= ack_now;
                    tcnt    <= tcnt + 1'b1;
                    if (xfer_done || tcnt == TO_LAST) begin
                        sys_req_valid      <= 1'b0;
                        sys_req_wr         <= 1'b0;
                        sys_req_addr       <= 8'h00;
                        sys_req_data_valid <= 1'b0;
                        sys_req_data       <= 8'h00;
                        status             <= xfer_done ? ST_OK : ST_TO;
                        if (!xfer_done) begin
                            rbuf <= '0;
                        end
                        state <= GAP;
                    end
                end
                GAP: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= status;
                    cnt       <= '0;
                    state     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        if (rsp_last) begin
                            rsp_valid <= 1'b0;
                            rsp_data  <= 8'h00;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            rsp_data <= rbuf[MGNT_REG_WIDTH-1 -: 8];
                            rbuf     <= rbuf << 8;
                            cnt      <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sys_req_master.sv
// Directed bench for sys_req_master: read, write, early ack, timeout, bad opcode, backpressure, reset mid-transfer.
module tb_sys_req_master;
    localparam int W  = 16;
    localparam int TO = 1024;

    logic       clk_if = 1'b0;
    logic       rst_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ready;
    logic       sys_req_valid;
    logic       sys_req_wr;
    logic [7:0] sys_req_addr;
    logic [7:0] sys_req_data;
    logic       sys_req_data_valid;
    logic       sys_req_ack;
    logic [7:0] sys_resp_data;
    logic       sys_resp_data_valid;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk_if = ~clk_if;

    sys_req_master #(
        .MGNT_REG_WIDTH(W),
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_W(16)
    ) dut (
        .clk_if(clk_if),
        .rst_if(rst_if),
        .cmd_valid(cmd_valid),
        .cmd_data(cmd_data),
        .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_ready(rsp_ready),
        .sys_req_valid(sys_req_valid),
        .sys_req_wr(sys_req_wr),
        .sys_req_addr(sys_req_addr),
        .sys_req_data(sys_req_data),
        .sys_req_data_valid(sys_req_data_valid),
        .sys_req_ack(sys_req_ack),
        .sys_resp_data(sys_resp_data),
        .sys_resp_data_valid(sys_resp_data_valid)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_cmd_rdy"}, cmd_ready, 1'b0);
        chk1({tag, "_rsp_vld"}, rsp_valid, 1'b0);
        chk8({tag, "_rsp_dat"}, rsp_data, 8'h00);
        chk1({tag, "_req_vld"}, sys_req_valid, 1'b0);
        chk1({tag, "_req_wr"}, sys_req_wr, 1'b0);
        chk8({tag, "_req_addr"}, sys_req_addr, 8'h00);
        chk8({tag, "_req_dat"}, sys_req_data, 8'h00);
        chk1({tag, "_req_dv"}, sys_req_data_valid, 1'b0);
    endtask

    // Called at a falling edge; returns at the falling edge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_data  = b;
        while (cmd_ready !== 1'b1 && t < 100) begin
            @(negedge clk_if);
            t++;
        end
        chk1("cmd_accept", cmd_ready, 1'b1);
        @(negedge clk_if);
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
    endtask

    // Entered during the REQ cycle: ack plus two data bytes on the first two XFER cycles.
    task automatic respond_read(input logic [7:0] b0, input logic [7:0] b1);
        @(negedge clk_if);
        sys_req_ack         = 1'b1;
        sys_resp_data_valid = 1'b1;
        sys_resp_data       = b0;
        @(negedge clk_if);
        sys_req_ack   = 1'b0;
        sys_resp_data = b1;
        @(negedge clk_if);
        sys_resp_data_valid = 1'b0;
        sys_resp_data       = 8'h00;
        chk1("rd_req_drop", sys_req_valid, 1'b0);
    endtask

    // Expects n response bytes (first byte in bits 23:16) with rsp_ready high, then an idle stream.
    task automatic expect_rsp(input string tag, input int n, input logic [23:0] bytes);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (rsp_valid !== 1'b1 && t < 2000) begin
                @(negedge clk_if);
                t++;
            end
            chk1({tag, "_vld"}, rsp_valid, 1'b1);
            chk8({tag, "_dat"}, rsp_data, bytes[23-8*i -: 8]);
            @(negedge clk_if);
        end
        chk1({tag, "_end"}, rsp_valid, 1'b0);
        chk1({tag, "_req_low"}, sys_req_valid, 1'b0);
    endtask

    initial begin
        int vcnt;
        rst_if              = 1'b0;
        cmd_valid           = 1'b0;
        cmd_data            = 8'h00;
        rsp_ready           = 1'b1;
        sys_req_ack         = 1'b0;
        sys_resp_data       = 8'h00;
        sys_resp_data_valid = 1'b0;

        repeat (3) @(negedge clk_if);
        chk_all_zero("reset");
        rst_if = 1'b1;
        @(negedge clk_if);
        chk1("rst_rel_rdy", cmd_ready, 1'b1);

        // Read 52,02 -> 00,12,34
        send_byte(8'h52);
        send_byte(8'h02);
        chk1("rd_req_vld", sys_req_valid, 1'b1);
        chk1("rd_req_wr", sys_req_wr, 1'b0);
        chk8("rd_req_addr", sys_req_addr, 8'h02);
        respond_read(8'h12, 8'h34);
        chk1("rd_gap_rsp", rsp_valid, 1'b0);
        @(negedge clk_if);
        chk1("rd_lat", rsp_valid, 1'b1);
        expect_rsp("rd_rsp", 3, 24'h001234);

        // Write 57,08,12,34 with a late ack
        send_byte(8'h57);
        send_byte(8'h08);
        send_byte(8'h12);
        send_byte(8'h34);
        chk1("wr_req_vld", sys_req_valid, 1'b1);
        chk1("wr_req_wr", sys_req_wr, 1'b1);
        chk8("wr_req_addr", sys_req_addr, 8'h08);
        chk1("wr_dv_req", sys_req_data_valid, 1'b0);
        @(negedge clk_if);
        chk1("wr_dv0", sys_req_data_valid, 1'b1);
        chk8("wr_d0", sys_req_data, 8'h12);
        @(negedge clk_if);
        chk1("wr_dv1", sys_req_data_valid, 1'b1);
        chk8("wr_d1", sys_req_data, 8'h34);
        @(negedge clk_if);
        chk1("wr_dv_end", sys_req_data_valid, 1'b0);
        chk8("wr_d_end", sys_req_data, 8'h00);
        repeat (3) @(negedge clk_if);
        chk1("wr_wait_ack", sys_req_valid, 1'b1);
        sys_req_ack = 1'b1;
        @(negedge clk_if);
        sys_req_ack = 1'b0;
        chk1("wr_req_drop", sys_req_valid, 1'b0);
        expect_rsp("wr_rsp", 1, 24'h000000);

        // Early ack in the first XFER cycle of a write
        send_byte(8'h57);
        send_byte(8'h20);
        send_byte(8'hAB);
        send_byte(8'hCD);
        @(negedge clk_if);
        sys_req_ack = 1'b1;
        chk1("ea_dv0", sys_req_data_valid, 1'b1);
        chk8("ea_d0", sys_req_data, 8'hAB);
        @(negedge clk_if);
        sys_req_ack = 1'b0;
        chk1("ea_dv1", sys_req_data_valid, 1'b1);
        chk8("ea_d1", sys_req_data, 8'hCD);
        chk1("ea_req_held", sys_req_valid, 1'b1);
        @(negedge clk_if);
        chk1("ea_req_drop", sys_req_valid, 1'b0);
        chk1("ea_dv_end", sys_req_data_valid, 1'b0);
        expect_rsp("ea_rsp", 1, 24'h000000);

        // Bad opcode
        send_byte(8'h41);
        chk1("bad_req_vld", sys_req_valid, 1'b0);
        chk1("bad_cmd_rdy", cmd_ready, 1'b0);
        expect_rsp("bad_rsp", 1, 24'h020000);

        // Timeout: REQ cycle plus TO XFER cycles with sys_req_valid high
        send_byte(8'h52);
        send_byte(8'h10);
        vcnt = 0;
        while (sys_req_valid === 1'b1 && vcnt < 3000) begin
            vcnt++;
            @(negedge clk_if);
        end
        chki("to_req_cycles", vcnt, TO + 1);
        expect_rsp("to_rsp", 1, 24'h010000);
        send_byte(8'h52);
        send_byte(8'h11);
        respond_read(8'h5A, 8'hA5);
        expect_rsp("to_next_rsp", 3, 24'h005AA5);

        // Response backpressure
        rsp_ready = 1'b0;
        send_byte(8'h52);
        send_byte(8'h33);
        respond_read(8'h77, 8'h88);
        @(negedge clk_if);
        for (int i = 0; i < 7; i++) begin
            chk1("bp_vld", rsp_valid, 1'b1);
            chk8("bp_dat", rsp_data, 8'h00);
            @(negedge clk_if);
        end
        rsp_ready = 1'b1;
        expect_rsp("bp_rsp", 3, 24'h007788);

        // Reset during XFER of a read
        send_byte(8'h52);
        send_byte(8'h44);
        @(negedge clk_if);
        chk1("mr_in_xfer", sys_req_valid, 1'b1);
        rst_if = 1'b0;
        @(negedge clk_if);
        chk_all_zero("mid_rst");
        rst_if = 1'b1;
        @(negedge clk_if);
        chk1("mr_rel_rdy", cmd_ready, 1'b1);
        repeat (4) @(negedge clk_if);
        chk1("mr_no_rsp", rsp_valid, 1'b0);
        send_byte(8'h52);
        send_byte(8'h55);
        respond_read(8'hC3, 8'h3C);
        expect_rsp("mr_next_rsp", 3, 24'h00C33C);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
